// File: rtl/lights_out_pkg.sv
// Lights Out shared types: FSM states, button bit positions, toggle-mask helper.
package lights_out_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        CHECK,
        WON,
        SCRAMBLE
    } state_t;

    // Bit positions in the button vector {Toggle, Up, Down, Left, Right}
    localparam int BTN_RIGHT  = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_UP     = 3;
    localparam int BTN_TOGGLE = 4;
    localparam int NBTN       = 5;

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam int          SCR_PRESSES = 16;

    // Cell idx is hit when pos is the cell itself or one of its in-grid neighbours
    function automatic logic [63:0] nbr_mask(input int pos, input int rows,
                                             input int cols);
        logic [63:0] m;
        int idx;
        m = '0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                idx = r * cols + c;
                if (pos == idx ||
                    (r > 0        && pos == idx - cols) ||
                    (r < rows - 1 && pos == idx + cols) ||
                    (c > 0        && pos == idx - 1) ||
                    (c < cols - 1 && pos == idx + 1))
                    m[idx[5:0]] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lights_out_edge_det.sv
// Registers the button vector and flags rising edges (cur=1, prev=0).
module lights_out_edge_det
    import lights_out_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn,
    output logic [NBTN-1:0] rise
);

    logic [NBTN-1:0] prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= '0;
        else       prev <= btn;
    end

    assign rise = btn & ~prev;

endmodule

// File: rtl/lights_out_controller.sv
// Lights Out sequencer: cursor, board, move counter and win flag.
// Optional LIGHTS_OUT_SCRAMBLE_EN: LFSR-driven board scramble after reset.
module lights_out_controller
    import lights_out_pkg::*;
#(
    parameter int                   ROWS         = 6,
    parameter int                   COLS         = 6,
    parameter logic [ROWS*COLS-1:0] INIT_PATTERN = 36'h0_0000_0043,
    parameter int                   MCNT_W       = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Left,
    input  logic                 Right,
    input  logic                 Up,
    input  logic                 Down,
    input  logic                 Toggle,
    output logic [5:0]           Position,
    output logic [ROWS*COLS-1:0] board,
    output logic [MCNT_W-1:0]    move_count,
    output logic                 busy,
    output logic                 win
);

    localparam int CELLS = ROWS * COLS;

    state_t          state;
    logic [2:0]      row;
    logic [2:0]      col;
    logic [NBTN-1:0] btn;
    logic [NBTN-1:0] rise;
    logic [CELLS-1:0] cur_mask;

    assign btn = {Toggle, Up, Down, Left, Right};

    lights_out_edge_det u_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .rise  (rise)
    );

    assign Position = 6'(int'(row) * COLS + int'(col));
    assign cur_mask = CELLS'(nbr_mask(int'(Position), ROWS, COLS));
    assign busy     = (state != IDLE);

`ifdef LIGHTS_OUT_SCRAMBLE_EN
    logic [15:0]      lfsr;
    logic [4:0]       scnt;
    logic [CELLS-1:0] scr_mask;
    logic [CELLS-1:0] zero_mask;

    assign scr_mask  = CELLS'(nbr_mask(int'(lfsr) % CELLS, ROWS, COLS));
    assign zero_mask = CELLS'(nbr_mask(0, ROWS, COLS));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            row        <= '0;
            col        <= '0;
            board      <= INIT_PATTERN;
            move_count <= '0;
            win        <= 1'b0;
`ifdef LIGHTS_OUT_SCRAMBLE_EN
            state      <= SCRAMBLE;
            lfsr       <= LFSR_SEED;
            scnt       <= '0;
`else
            state      <= IDLE;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    // Only the highest-priority edge acts; a clamped move still wins
                    if (rise[BTN_TOGGLE]) begin
                        state <= APPLY;
                    end else if (rise[BTN_UP]) begin
                        if (row != 3'd0) row <= row - 3'd1;
                    end else if (rise[BTN_DOWN]) begin
                        if (row != 3'(ROWS - 1)) row <= row + 3'd1;
                    end else if (rise[BTN_LEFT]) begin
                        if (col != 3'd0) col <= col - 3'd1;
                    end else if (rise[BTN_RIGHT]) begin
                        if (col != 3'(COLS - 1)) col <= col + 3'd1;
                    end
                end
                APPLY: begin
                    board <= board ^ cur_mask;
                    if (move_count != '1) move_count <= move_count + 1'b1;
                    state <= CHECK;
                end
                CHECK: begin
                    if (board == '0) begin
                        win   <= 1'b1;
                        state <= WON;
                    end else begin
                        state <= IDLE;
                    end
                end
                WON: begin
                end
                SCRAMBLE: begin
`ifdef LIGHTS_OUT_SCRAMBLE_EN
                    if (scnt != 5'(SCR_PRESSES)) begin
                        board <= board ^ scr_mask;
                        lfsr  <= {lfsr[14:0],
                                  lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                        scnt  <= scnt + 5'd1;
                    end else begin
                        if (board == '0) board <= board ^ zero_mask;
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lights_out_controller.sv
// Scoreboard bench for lights_out_controller against a grid-level model.
module tb_lights_out_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        Left, Right, Up, Down, Toggle;
    logic [5:0]  Position;
    logic [35:0] board;
    logic [9:0]  move_count;
    logic        busy, win;

    logic        zreset;
    logic [4:0]  zb;
    logic [5:0]  zpos;
    logic [35:0] zboard;
    logic [9:0]  zcnt;
    logic        zbusy, zwin;

    always #5 clk = ~clk;

    lights_out_controller dut (
        .clk(clk), .reset(reset),
        .Left(Left), .Right(Right), .Up(Up), .Down(Down), .Toggle(Toggle),
        .Position(Position), .board(board), .move_count(move_count),
        .busy(busy), .win(win)
    );

    lights_out_controller #(.INIT_PATTERN(36'h0)) dut_z (
        .clk(clk), .reset(zreset),
        .Left(zb[1]), .Right(zb[0]), .Up(zb[3]), .Down(zb[2]), .Toggle(zb[4]),
        .Position(zpos), .board(zboard), .move_count(zcnt),
        .busy(zbusy), .win(zwin)
    );

    localparam logic [4:0] R = 5'b00001, L = 5'b00010, D = 5'b00100;
    localparam logic [4:0] U = 5'b01000, T = 5'b10000;

    typedef struct {
        logic [5:0]  pos;
        logic [35:0] board;
        logic [9:0]  cnt;
        logic        busy;
        logic        win;
        logic        bchk;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Model: grid coordinates, phase 0 idle / 1 toggle pending / 2 win check / 3 won
    int          m_row, m_col, m_phase, m_cnt, m_scr;
    logic [35:0] m_board, scr_board;
    logic        m_win;
    logic [4:0]  m_prev;

    function automatic logic [35:0] press(input logic [35:0] b, input int p);
        int pr, pc, dr, dc;
        pr = p / 6;
        pc = p % 6;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                dr = (r > pr) ? r - pr : pr - r;
                dc = (c > pc) ? c - pc : pc - c;
                if (dr + dc <= 1) b[r*6+c] = ~b[r*6+c];
            end
        return b;
    endfunction

`ifdef LIGHTS_OUT_SCRAMBLE_EN
    function automatic logic [35:0] scrambled();
        logic [15:0] l;
        logic [35:0] b;
        l = 16'hACE1;
        b = 36'h43;
        for (int i = 0; i < 16; i++) begin
            b = press(b, int'(l) % 36);
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        if (b == 36'h0) b = press(b, 0);
        return b;
    endfunction
`endif

    task automatic model_clock(input logic [4:0] b, input logic rst);
        logic [4:0] rise;
        exp_t e;
        if (rst) begin
            m_row = 0; m_col = 0; m_phase = 0; m_cnt = 0;
            m_board = 36'h43; m_win = 1'b0; m_prev = 5'b0;
`ifdef LIGHTS_OUT_SCRAMBLE_EN
            m_scr = 17;
`else
            m_scr = 0;
`endif
        end else begin
            rise = b & ~m_prev;
            m_prev = b;
            if (m_scr > 0) begin
                m_scr--;
                if (m_scr == 0) m_board = scr_board;
            end else if (m_phase == 0) begin
                if (rise[4])      m_phase = 1;
                else if (rise[3]) m_row = (m_row > 0) ? m_row - 1 : 0;
                else if (rise[2]) m_row = (m_row < 5) ? m_row + 1 : 5;
                else if (rise[1]) m_col = (m_col > 0) ? m_col - 1 : 0;
                else if (rise[0]) m_col = (m_col < 5) ? m_col + 1 : 5;
            end else if (m_phase == 1) begin
                m_board = press(m_board, m_row * 6 + m_col);
                m_cnt = (m_cnt < 1023) ? m_cnt + 1 : 1023;
                m_phase = 2;
            end else if (m_phase == 2) begin
                if (m_board == 36'h0) begin
                    m_win = 1'b1;
                    m_phase = 3;
                end else begin
                    m_phase = 0;
                end
            end
        end
        e.pos   = 6'(m_row * 6 + m_col);
        e.board = m_board;
        e.cnt   = 10'(m_cnt);
        e.busy  = (m_scr > 0) || (m_phase != 0);
        e.win   = m_win;
        e.bchk  = (m_scr == 0);
        q.push_back(e);
    endtask

    task automatic step(input logic [4:0] b, input logic rst);
        @(negedge clk);
        {Toggle, Up, Down, Left, Right} = b;
        reset = rst;
        model_clock(b, rst);
    endtask

    task automatic idle(input int n);
        repeat (n) step(5'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (Position !== e.pos || move_count !== e.cnt || busy !== e.busy ||
                win !== e.win || (e.bchk && board !== e.board)) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got pos=%0d board=%h cnt=%0d busy=%b win=%b, want pos=%0d board=%h cnt=%0d busy=%b win=%b",
                         $time, Position, board, move_count, busy, win,
                         e.pos, e.board, e.cnt, e.busy, e.win);
            end
        end
    end

    task automatic zstep(input logic [4:0] b, input logic rst);
        @(negedge clk);
        zb = b;
        zreset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic zchk(input string name, input logic [63:0] got,
                        input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        logic [4:0] b;
`ifdef LIGHTS_OUT_SCRAMBLE_EN
        scr_board = scrambled();
`else
        scr_board = 36'h43;
`endif
        {Toggle, Up, Down, Left, Right} = 5'b0;
        reset = 1'b1;
        zb = 5'b0;
        zreset = 1'b1;

        step(5'b0, 1'b1);
        step(5'b0, 1'b1);
        idle(20);
        for (int i = 0; i < 7; i++) begin
            step(R, 1'b0);
            idle(2);
        end
        repeat (10) step(D, 1'b0);
        step(5'b0, 1'b0);

        step(5'b0, 1'b1);
        idle(20);
        step(R | D, 1'b0);
        step(5'b0, 1'b0);

        step(R, 1'b0);
        step(5'b0, 1'b0);
        step(T, 1'b0);
        step(5'b0, 1'b1);
        idle(20);

        step(T, 1'b0);
        idle(3);
        step(R, 1'b0);
        step(5'b0, 1'b0);
        step(T, 1'b0);
        idle(3);

        b = 5'b0;
        repeat (3) begin
            step(5'b0, 1'b1);
            idle(20);
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 2) != 0)
                    b = ($urandom_range(0, 2) == 0) ? 5'($urandom) & 5'($urandom) : 5'b0;
                step(b, $urandom_range(0, 199) == 0);
            end
        end
        step(5'b0, 1'b0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end

`ifndef LIGHTS_OUT_SCRAMBLE_EN
        zstep(5'b0, 1'b1);
        zstep(5'b0, 1'b1);
        zchk("z_reset_board", 64'(zboard), 64'h0);
        zstep(T, 1'b0);
        zstep(5'b0, 1'b0);
        zchk("z_toggle0_board", 64'(zboard), 64'h43);
        zchk("z_toggle0_cnt", 64'(zcnt), 64'd1);
        zstep(5'b0, 1'b0);
        zchk("z_toggle0_idle", 64'({zbusy, zwin}), 64'b00);

        zstep(5'b0, 1'b1);
        zstep(D, 1'b0); zstep(5'b0, 1'b0);
        zstep(D, 1'b0); zstep(5'b0, 1'b0);
        zstep(R, 1'b0); zstep(5'b0, 1'b0);
        zstep(R, 1'b0); zstep(5'b0, 1'b0);
        zchk("z_pos14", 64'(zpos), 64'd14);
        zstep(T, 1'b0); zstep(5'b0, 1'b0); zstep(5'b0, 1'b0);
        zchk("z_toggle14_board", 64'(zboard), 64'h10E100);
        zchk("z_toggle14_win", 64'(zwin), 64'd0);
        zstep(T, 1'b0); zstep(5'b0, 1'b0); zstep(5'b0, 1'b0);
        zchk("z_clear_board", 64'(zboard), 64'h0);
        zchk("z_clear_cnt", 64'(zcnt), 64'd2);
        zchk("z_clear_win", 64'({zbusy, zwin}), 64'b11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
